ring_token_arbiter: RTL and testbench

//  Round-robin arbiter sharing one resource between N requesters.
//  A one-hot ring token marks the priority position. After each grant completes,
//  the token rotates one place past the last owner.

---
 rtl/ring_arb_pkg.sv | 24 ++
 rtl/ring_token_rotator.sv | 27 ++
 rtl/ring_token_arbiter.sv | 147 ++++++++++++++
 tb/tb_ring_token_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring token arbiter.
package ring_arb_pkg;

  localparam int STATE_W = 2;
  localparam int OH_MAX  = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Binary index of a one-hot vector (up to 16 bits); OR-reduction form so
  // a legal one-hot input never builds a priority chain.
  function automatic logic [3:0] onehot2bin(input logic [OH_MAX-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < OH_MAX; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_token_rotator.sv
// One-hot priority ring register. Resets to bit 0; on strobe it loads the
// base vector rotated left by one place, so the token lands just past the
// client that last owned the resource.
module ring_token_rotator #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         i_strobe,
  input  logic [N-1:0] i_base,
  output logic [N-1:0] o_token
);

  logic [N-1:0] r_token;

  // Token register: reset to position 0, rotate-left of the base on strobe.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_token <= N'(1);
    end else if (i_strobe) begin
      r_token <= {i_base[N-2:0], i_base[N-1]};
    end
  end

  assign o_token = r_token;

endmodule

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter with a one-hot ring token marking priority.
// Optional feature: define ARB_TIMEOUT_EN to force release after HOLD_MAX
// grant cycles (Johnson-counter timer, timeout pulse on forced release).
//
// Handshake: req[i] is a level held by client i until it has been served.
// gnt is one-hot and registered; a client owns the resource for every cycle
// its gnt bit is 1. Ownership ends on done=1 or on the owner dropping req;
// gnt falls at the next edge and one dead cycle (RELEASE) follows, so two
// grants never overlap or abut.
module ring_token_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8,
  localparam int ID_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               en,
  input  logic [N-1:0]       req,
  input  logic               done,
  output logic [N-1:0]       gnt,
  output logic [ID_W-1:0]    owner_id,
  output logic               busy,
  output logic [N-1:0]       token,
  output logic               timeout,
  output logic [STATE_W-1:0] dbg_state
);

  arb_state_e      r_state;
  logic [N-1:0]    r_gnt;
  logic [ID_W-1:0] r_owner;
  logic            r_busy;
  logic            r_timeout;

  logic [N-1:0]    w_token;
  logic [3:0]      w_tok_bin;
  logic            w_found;
  logic [ID_W-1:0] w_sel;
  logic [N-1:0]    w_sel_oh;
  logic            w_owner_req;
  logic            w_to_hit;
  logic            w_release;
  logic            w_forced;

  assign w_tok_bin = onehot2bin(OH_MAX'(w_token));

  // Scan requests upward from the token position (inclusive), wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && req[(int'(w_tok_bin) + i) % N]) begin
        w_found = 1'b1;
        w_sel   = ID_W'((int'(w_tok_bin) + i) % N);
      end
    end
  end

  assign w_sel_oh    = N'(1) << w_sel;
  assign w_owner_req = req[r_owner];
  assign w_release   = (r_state == GRANT) && (done || !w_owner_req || w_to_hit);
  // A timeout only counts when nothing else would have ended the grant.
  assign w_forced    = w_to_hit && !done && w_owner_req;

`ifdef ARB_TIMEOUT_EN
  localparam int            JW    = HOLD_MAX / 2;
  localparam logic [JW-1:0] JTERM = JW'(1) << (JW - 1);

  logic [JW-1:0] r_john;
  logic [JW-1:0] w_john_nxt;

  // Johnson step: shift left, feeding back the inverted MSB.
  always_comb begin
    w_john_nxt    = '0;
    w_john_nxt[0] = ~r_john[JW-1];
    for (int i = 1; i < JW; i++) begin
      w_john_nxt[i] = r_john[i-1];
    end
  end

  // Timer sits at zero outside GRANT and advances once per GRANT cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_john <= '0;
    end else if (r_state != GRANT) begin
      r_john <= '0;
    end else begin
      r_john <= w_john_nxt;
    end
  end

  // Terminal pattern 10..0 is reached on the HOLD_MAX-th GRANT cycle.
  assign w_to_hit = (r_state == GRANT) && (r_john == JTERM);
`else
  assign w_to_hit = 1'b0;
`endif

  // Arbitration FSM with registered grant, owner, busy and timeout.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en && w_found) begin
            r_gnt   <= w_sel_oh;
            r_owner <= w_sel;
            r_busy  <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= w_forced;
            r_state   <= RELEASE;
          end
        end
        RELEASE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  ring_token_rotator #(.N(N)) u_rotator (
    .clk      (clk),
    .clr_n    (clr_n),
    .i_strobe (w_release),
    .i_base   (r_gnt),
    .o_token  (w_token)
  );

  assign gnt       = r_gnt;
  assign owner_id  = r_owner;
  assign busy      = r_busy;
  assign token     = w_token;
  assign timeout   = r_timeout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Bench for ring_token_arbiter (N=4, HOLD_MAX=8), default or ARB_TIMEOUT_EN build.
module tb_ring_token_arbiter;

  localparam int N        = 4;
  localparam int HOLD_MAX = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] owner_id;
  logic       busy;
  logic [3:0] token;
  logic       timeout;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit run_cmp  = 1'b0;

  ring_token_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .owner_id  (owner_id),
    .busy      (busy),
    .token     (token),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Owner as an integer (-1 = none), token as an integer position,
  // a flag for the dead cycle after a release, and a grant-length counter.
  int m_owner = -1;
  int m_tok   = 0;
  int m_held  = 0;
  bit m_dead  = 1'b0;
  bit m_to    = 1'b0;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_owner = -1;
      m_tok   = 0;
      m_held  = 0;
      m_dead  = 1'b0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner >= 0) begin
        m_held++;
        if (done || !req[m_owner] || (TO_EN && m_held >= HOLD_MAX)) begin
          m_to    = !done && req[m_owner];
          m_tok   = (m_owner + 1) % N;
          m_owner = -1;
          m_dead  = 1'b1;
        end
      end else if (m_dead) begin
        m_dead = 1'b0;
      end else if (en && req != 4'b0000) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req[(m_tok + k) % N]) m_owner = (m_tok + k) % N;
        end
        m_held = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run_cmp) begin
      logic [3:0] exp_gnt;
      logic [3:0] exp_tok;
      exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      exp_tok = 4'b0001 << m_tok;
      chk("cyc_gnt", 32'(gnt), 32'(exp_gnt));
      chk("cyc_busy", 32'(busy), 32'(m_owner >= 0));
      chk("cyc_token", 32'(token), 32'(exp_tok));
      chk("cyc_timeout", 32'(timeout), 32'(m_to));
      if (m_owner >= 0) chk("cyc_owner_id", 32'(owner_id), 32'(m_owner));
      chk("inv_token_onehot", 32'($onehot(token)), 32'd1);
      chk("inv_gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r, input logic e);
    clr_n = 1'b0;
    req   = r;
    en    = e;
    done  = 1'b0;
    tick();
    tick();
    clr_n = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // T1: reset with all requests raised
    clr_n = 1'b0; req = 4'b1111; en = 1'b1; done = 1'b0;
    tick();
    run_cmp = 1'b1;
    tick();
    chk("t1_gnt", 32'(gnt), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_token", 32'(token), 32'h1);
    chk("t1_timeout", 32'(timeout), 32'h0);
    chk("t1_state_idle", 32'(dbg_state), 32'h0);

    // T2: req=1010 from token 0001
    req = 4'b1010; clr_n = 1'b1;
    tick();
    chk("t2_first_gnt", 32'(gnt), 32'h2);
    done = 1'b1;
    tick();
    chk("t2_release_gnt", 32'(gnt), 32'h0);
    chk("t2_token", 32'(token), 32'h4);
    done = 1'b0;
    tick();
    chk("t2_dead_gnt", 32'(gnt), 32'h0);
    tick();
    chk("t2_second_gnt", 32'(gnt), 32'h8);
    req = 4'b0000;
    tick();
    chk("t2_wrap_token", 32'(token), 32'h1);
    tick();

    // T3: all requesting, done pulsed after each grant
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] seq;
      seq = 4'b0001 << (k % 4);
      tick();
      chk("t3_gnt", 32'(gnt), 32'(seq));
      done = 1'b1;
      tick();
      chk("t3_gap_release", 32'(gnt), 32'h0);
      done = 1'b0;
      tick();
      chk("t3_gap_dead", 32'(gnt), 32'h0);
    end
    req = 4'b0000;
    tick();

    // T4: en=0 blocks grants; done outside GRANT ignored
    do_reset(4'b1111, 1'b0);
    for (int k = 0; k < 10; k++) begin
      done = k[0];
      tick();
      chk("t4_blocked_gnt", 32'(gnt), 32'h0);
    end
    done = 1'b0;
    en = 1'b1;
    tick();
    chk("t4_enable_gnt", 32'(gnt), 32'h1);
    en = 1'b0; done = 1'b1;
    tick();
    chk("t4_en0_release", 32'(gnt), 32'h0);
    chk("t4_en0_token", 32'(token), 32'h2);
    done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_en0_no_new", 32'(gnt), 32'h0);
    end
    en = 1'b1;
    tick();
    chk("t4_reenable_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    tick();

    // T5: single requester holding without done
    do_reset(4'b0100, 1'b1);
    tick();
    chk("t5_gnt", 32'(gnt), 32'h4);
    if (TO_EN) begin
      for (int k = 2; k <= HOLD_MAX; k++) begin
        tick();
        chk("t5_hold", 32'(gnt), 32'h4);
        chk("t5_no_to", 32'(timeout), 32'h0);
      end
      tick();
      chk("t5_forced_gnt", 32'(gnt), 32'h0);
      chk("t5_timeout", 32'(timeout), 32'h1);
      chk("t5_token", 32'(token), 32'h8);
      req = 4'b0000;
      tick();
      chk("t5_timeout_pulse", 32'(timeout), 32'h0);
    end else begin
      for (int k = 0; k < 20; k++) begin
        tick();
        chk("t5_hold", 32'(gnt), 32'h4);
        chk("t5_no_to", 32'(timeout), 32'h0);
      end
      req = 4'b0000;
      tick();
      chk("t5_drop_gnt", 32'(gnt), 32'h0);
      chk("t5_token", 32'(token), 32'h8);
    end
    tick();

    // T6: asynchronous reset in the middle of a grant
    do_reset(4'b0100, 1'b1);
    tick();
    tick();
    req = 4'b0110;
    tick();
    chk("t6_nonowner_ignored", 32'(gnt), 32'h4);
    #2 clr_n = 1'b0;
    #1;
    chk("t6_async_gnt", 32'(gnt), 32'h0);
    chk("t6_async_busy", 32'(busy), 32'h0);
    chk("t6_async_token", 32'(token), 32'h1);
    #3 clr_n = 1'b1;
    tick();
    chk("t6_lowest_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    tick();

    run_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
